// File: rtl/ram_1p_req_pkg.sv
// Shared types and constants for the single-port RAM requester and its response FIFO.
package ram_1p_req_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned RspDepth = 2;
    localparam int unsigned RspCntW  = $clog2(RspDepth + 1);

    // One-cycle pipe slot between an accepted request and its FIFO push.
    typedef struct packed {
        logic valid;
        logic write;
        logic err;
    } infl_t;

endpackage

// File: rtl/ram_1p_rsp_fifo.sv
// Two-entry shift-style response FIFO; slot 0 is the head, so outputs come straight from flops.
module ram_1p_rsp_fifo
    import ram_1p_req_pkg::*;
#(
    parameter type item_t = logic
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  item_t              data_i,
    input  logic               pop_i,
    output logic               valid_o,
    output item_t              head_o,
    output logic [RspCntW-1:0] count_o
);

    item_t              slot_q [RspDepth];
    item_t              slot_d [RspDepth];
    logic [RspCntW-1:0] count_q, count_d;
    logic [RspCntW-1:0] wr_idx;
    logic               pop_eff;

    always_comb begin
        slot_d  = slot_q;
        pop_eff = pop_i && (count_q != '0);
        wr_idx  = count_q - RspCntW'(pop_eff);
        if (pop_eff) begin
            for (int i = 0; i < int'(RspDepth) - 1; i++) begin
                slot_d[i] = slot_q[i+1];
            end
        end
        if (push_i) begin
            for (int i = 0; i < int'(RspDepth); i++) begin
                if (wr_idx == RspCntW'(i)) begin
                    slot_d[i] = data_i;
                end
            end
        end
        count_d = count_q + RspCntW'(push_i) - RspCntW'(pop_eff);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            // NOTE: storage is tiny and drives rsp_* directly, so it is reset to keep outputs at 0.
            for (int i = 0; i < int'(RspDepth); i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            slot_q  <= slot_d;
        end
    end

    assign valid_o = (count_q != '0);
    assign head_o  = slot_q[0];
    assign count_o = count_q;

    // Upstream credit logic must make this unreachable.
    assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && !pop_eff && count_q == RspCntW'(RspDepth)));

endmodule

// File: rtl/ram_1p_requester.sv
// Valid/ready request stream to single-port RAM cycles, with a zeroizing sweep after reset and
// a credit-limited response FIFO that catches one-cycle rdata under back-pressure.
module ram_1p_requester
    import ram_1p_req_pkg::*;
#(
    parameter int unsigned       Width       = 32,
    parameter int unsigned       Depth       = 512,
    parameter bit                InitOnReset = 1'b1,
    parameter logic [Width-1:0]  InitValue   = '0,
    localparam int unsigned      Aw          = $clog2(Depth),
    localparam int unsigned      NB          = Width / 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [Aw-1:0]    req_addr_i,
    input  logic [Width-1:0] req_wdata_i,
    input  logic [NB-1:0]    req_be_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [Width-1:0] rsp_rdata_o,
    output logic             rsp_write_o,
    output logic             rsp_err_o,
    output logic             init_done_o,
    output logic             ram_req_o,
    output logic             ram_write_o,
    output logic [Aw-1:0]    ram_addr_o,
    output logic [Width-1:0] ram_wdata_o,
    output logic [Width-1:0] ram_wmask_o,
    input  logic [Width-1:0] ram_rdata_i
);

    typedef struct packed {
        logic [Width-1:0] rdata;
        logic             write;
        logic             err;
    } rsp_t;

    localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

    state_e             state_q, state_d;
    logic [Aw-1:0]      cnt_q, cnt_d;
    logic               init_done_q, init_done_d;
    infl_t              infl_q, infl_d;

    logic [RspCntW-1:0] fifo_count;
    logic [RspCntW-1:0] occ;
    logic               req_err;
    logic [Width-1:0]   wmask;
    rsp_t               push_data;
    rsp_t               rsp_head;

    always_comb begin
        wmask = '0;
        for (int b = 0; b < int'(NB); b++) begin
            wmask[8*b +: 8] = {8{req_be_i[b]}};
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        infl_d      = '0;
        req_ready_o = 1'b0;
        ram_req_o   = 1'b0;
        ram_write_o = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_wmask_o = '0;
        occ         = fifo_count + RspCntW'(infl_q.valid);
        req_err     = (32'(req_addr_i) >= Depth);

        if (state_q == INIT) begin
            if (!rst_i) begin
                ram_req_o   = 1'b1;
                ram_write_o = 1'b1;
                ram_addr_o  = cnt_q;
                ram_wdata_o = InitValue;
                ram_wmask_o = '1;
                if (cnt_q == LastAddr) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end else begin
            // A full pipe may still accept when the head leaves this same cycle.
            req_ready_o = !rst_i && ((occ < RspCntW'(RspDepth)) ||
                          (occ == RspCntW'(RspDepth) && rsp_valid_o && rsp_ready_i));
            if (req_valid_i && req_ready_o) begin
                ram_req_o   = !req_err;
                ram_write_o = req_write_i;
                ram_addr_o  = req_addr_i;
                ram_wdata_o = req_wdata_i;
                ram_wmask_o = wmask;
                infl_d      = '{valid: 1'b1, write: req_write_i, err: req_err};
            end
        end

        init_done_d = (state_d == RUN);
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            state_q     <= InitOnReset ? INIT : RUN;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            infl_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            infl_q      <= infl_d;
        end
    end

    assign push_data = '{
        rdata: (infl_q.write || infl_q.err) ? '0 : ram_rdata_i,
        write: infl_q.write,
        err:   infl_q.err
    };

    ram_1p_rsp_fifo #(
        .item_t (rsp_t)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (infl_q.valid),
        .data_i  (push_data),
        .pop_i   (rsp_ready_i),
        .valid_o (rsp_valid_o),
        .head_o  (rsp_head),
        .count_o (fifo_count)
    );

    assign rsp_rdata_o = rsp_head.rdata;
    assign rsp_write_o = rsp_head.write;
    assign rsp_err_o   = rsp_head.err;
    assign init_done_o = init_done_q;

endmodule
